// File: rtl/vga_timing_gen_if.sv
// Video timing bundle: raster counters, decoded sync/blank strobes and frame
// bookkeeping. The timing generator drives it; display pipelines consume it.
interface vga_timing_gen_if;
  logic [9:0] X_pix;
  logic [9:0] Y_pix;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       frame_start;
  logic [7:0] frame_count;

  modport master (
    output X_pix, Y_pix, hsync, vsync, video_on, frame_start, frame_count
  );

  modport slave (
    input X_pix, Y_pix, hsync, vsync, video_on, frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing generator: free-running pixel/line counters with decoded
// hsync/vsync/video_on, optionally delayed so they line up with a pixel
// pipeline that registers X_pix/Y_pix before producing colour.
// The four horizontal and four vertical values must each sum to at most 1023.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int SYNC_POL  = 0,
  parameter int PIPE_DLY  = 1
) (
  input  logic             pixel_clk,
  input  logic             rst,
  vga_timing_gen_if.master vga
);

  localparam logic [9:0] H_TOTAL      = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);
  localparam logic [9:0] H_VIS        = 10'(H_VISIBLE);
  localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_TOTAL      = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK);
  localparam logic [9:0] V_VIS        = 10'(V_VISIBLE);
  localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  // Level that means "sync asserted" on the hsync/vsync pins.
  localparam logic SYNC_ACT = (SYNC_POL != 0);
  // {hsync, vsync, video_on} when nothing is being signalled.
  localparam logic [2:0] IDLE_VEC = {~SYNC_ACT, ~SYNC_ACT, 1'b0};

  logic [9:0] x_reg, x_next;
  logic [9:0] y_reg, y_next;
  logic [7:0] frame_count_reg, frame_count_next;
  logic       x_last, y_last;
  logic [2:0] raw_vec;
  logic [2:0] out_vec;

  assign x_last = (x_reg == H_TOTAL - 10'd1);
  assign y_last = (y_reg == V_TOTAL - 10'd1);

  // Next raster position: X every clock, Y on X wrap, frame count on Y wrap.
  always_comb begin
    x_next           = x_reg + 10'd1;
    y_next           = y_reg;
    frame_count_next = frame_count_reg;
    if (x_last) begin
      x_next = '0;
      if (y_last) begin
        y_next           = '0;
        frame_count_next = frame_count_reg + 8'd1;
      end else begin
        y_next = y_reg + 10'd1;
      end
    end
  end

  // Counter state; reset clears the raster immediately, not at the next edge.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      x_reg           <= '0;
      y_reg           <= '0;
      frame_count_reg <= '0;
    end else begin
      x_reg           <= x_next;
      y_reg           <= y_next;
      frame_count_reg <= frame_count_next;
    end
  end

  // Undelayed decode of the counters; forced idle during reset so the
  // zero-delay build does not show video_on at position (0,0) while held.
  always_comb begin
    raw_vec = IDLE_VEC;
    if (!rst) begin
      raw_vec[2] = (x_reg >= H_SYNC_START && x_reg < H_SYNC_END) ? SYNC_ACT : ~SYNC_ACT;
      raw_vec[1] = (y_reg >= V_SYNC_START && y_reg < V_SYNC_END) ? SYNC_ACT : ~SYNC_ACT;
      raw_vec[0] = (x_reg < H_VIS) && (y_reg < V_VIS);
    end
  end

  generate
    if (PIPE_DLY == 0) begin : g_nopipe
      assign out_vec = raw_vec;
    end else begin : g_pipe
      logic [2:0] stage_reg [PIPE_DLY];

      // Shift register matching the latency of a downstream pixel pipeline.
      always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < PIPE_DLY; i++) stage_reg[i] <= IDLE_VEC;
        end else begin
          stage_reg[0] <= raw_vec;
          for (int i = 1; i < PIPE_DLY; i++) stage_reg[i] <= stage_reg[i-1];
        end
      end

      assign out_vec = stage_reg[PIPE_DLY-1];
    end
  endgenerate

  assign vga.X_pix       = x_reg;
  assign vga.Y_pix       = y_reg;
  assign vga.frame_count = frame_count_reg;
  assign vga.hsync       = out_vec[2];
  assign vga.vsync       = out_vec[1];
  assign vga.video_on    = out_vec[0];
  // Marks the origin pixel itself, so it is never delayed with the strobes.
  assign vga.frame_start = !rst && (x_reg == 10'd0) && (y_reg == 10'd0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: small-raster builds (16x11 total) with delays
// 0, 1 and 2 plus one default 800x525 build, all on one clock and reset.
module tb_vga_timing_gen;

  logic pixel_clk = 1'b0;
  logic rst       = 1'b1;
  always #5 pixel_clk = ~pixel_clk;

  vga_timing_gen_if if_a ();
  vga_timing_gen_if if_b ();
  vga_timing_gen_if if_c ();
  vga_timing_gen_if if_d ();

  // Small raster, active-low sync, one-clock strobe delay.
  vga_timing_gen #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
                   .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
                   .SYNC_POL(0), .PIPE_DLY(1))
    dut_a (.pixel_clk(pixel_clk), .rst(rst), .vga(if_a));

  // Small raster, active-high sync, pure decode.
  vga_timing_gen #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
                   .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
                   .SYNC_POL(1), .PIPE_DLY(0))
    dut_b (.pixel_clk(pixel_clk), .rst(rst), .vga(if_b));

  // Default 640x480 timing.
  vga_timing_gen dut_c (.pixel_clk(pixel_clk), .rst(rst), .vga(if_c));

  // Small raster, active-low sync, two-clock strobe delay.
  vga_timing_gen #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
                   .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
                   .SYNC_POL(0), .PIPE_DLY(2))
    dut_d (.pixel_clk(pixel_clk), .rst(rst), .vga(if_d));

  localparam int SH = 16;
  localparam int SV = 11;
  localparam int SF = SH * SV;

  int checks   = 0;
  int failures = 0;
  int n        = 0;

  int von_a_cnt   = 0;
  int vs_a_low    = 0;
  int hs_c_low    = 0;
  int fs_a_cnt    = 0;

  typedef struct {
    int   n;
    int   x;
    int   y;
    logic hs;
    logic vs;
    logic von;
    logic fs;
    int   fc;
    logic hsb;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s n=%0d actual=%0d expected=%0d", name, n, act, exp);
    end
  endtask

  // Undelayed {h_active, v_active, visible} of raster step m; m<0 is "before
  // release", i.e. nothing active.
  function automatic logic [2:0] raw_fn(input int m, input int hv, input int hf,
                                        input int hs, input int hb, input int vv,
                                        input int vf, input int vs, input int vb);
    int   ht, vt, x, y;
    logic h_on, v_on, vis;
    if (m < 0) return 3'b000;
    ht   = hv + hf + hs + hb;
    vt   = vv + vf + vs + vb;
    x    = m % ht;
    y    = (m / ht) % vt;
    h_on = (x >= hv + hf) && (x < hv + hf + hs);
    v_on = (y >= vv + vf) && (y < vv + vf + vs);
    vis  = (x < hv) && (y < vv);
    return {h_on, v_on, vis};
  endfunction

  task automatic check_all();
    logic [2:0] r;
    // dut_a: active-low, one clock late
    r = raw_fn(n - 1, 8, 2, 3, 3, 6, 1, 2, 2);
    check("a_x", int'(if_a.X_pix), n % SH);
    check("a_y", int'(if_a.Y_pix), (n / SH) % SV);
    check("a_hs", int'(if_a.hsync), int'(!r[2]));
    check("a_vs", int'(if_a.vsync), int'(!r[1]));
    check("a_von", int'(if_a.video_on), int'(r[0]));
    check("a_fs", int'(if_a.frame_start), int'(n % SF == 0));
    check("a_fc", int'(if_a.frame_count), (n / SF) % 256);
    // dut_b: active-high, same cycle
    r = raw_fn(n, 8, 2, 3, 3, 6, 1, 2, 2);
    check("b_x", int'(if_b.X_pix), n % SH);
    check("b_hs", int'(if_b.hsync), int'(r[2]));
    check("b_vs", int'(if_b.vsync), int'(r[1]));
    check("b_von", int'(if_b.video_on), int'(r[0]));
    check("b_fs", int'(if_b.frame_start), int'(n % SF == 0));
    // dut_d: active-low, two clocks late
    r = raw_fn(n - 2, 8, 2, 3, 3, 6, 1, 2, 2);
    check("d_hs", int'(if_d.hsync), int'(!r[2]));
    check("d_vs", int'(if_d.vsync), int'(!r[1]));
    check("d_von", int'(if_d.video_on), int'(r[0]));
    // dut_c: default timing, first lines only
    if (n < 2000) begin
      r = raw_fn(n - 1, 640, 16, 96, 48, 480, 10, 2, 33);
      check("c_x", int'(if_c.X_pix), n % 800);
      check("c_y", int'(if_c.Y_pix), n / 800);
      check("c_hs", int'(if_c.hsync), int'(!r[2]));
      check("c_vs", int'(if_c.vsync), int'(!r[1]));
      check("c_von", int'(if_c.video_on), int'(r[0]));
      check("c_fs", int'(if_c.frame_start), int'(n == 0));
    end
  endtask

  task automatic step();
    @(negedge pixel_clk);
    n++;
    check_all();
    if (n >= 1 && n <= SF) begin
      von_a_cnt += int'(if_a.video_on);
      vs_a_low  += int'(!if_a.vsync);
    end
    if (n >= 801 && n <= 1600) hs_c_low += int'(!if_c.hsync);
    fs_a_cnt += int'(if_a.frame_start);
    if (n == SF * 255) check("a_fc_255", int'(if_a.frame_count), 255);
    if (n == SF * 256) check("a_fc_wrap", int'(if_a.frame_count), 0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_a_x"}, int'(if_a.X_pix), 0);
    check({tag, "_a_y"}, int'(if_a.Y_pix), 0);
    check({tag, "_a_fc"}, int'(if_a.frame_count), 0);
    check({tag, "_a_fs"}, int'(if_a.frame_start), 0);
    check({tag, "_a_hs"}, int'(if_a.hsync), 1);
    check({tag, "_a_vs"}, int'(if_a.vsync), 1);
    check({tag, "_a_von"}, int'(if_a.video_on), 0);
    check({tag, "_b_hs"}, int'(if_b.hsync), 0);
    check({tag, "_b_vs"}, int'(if_b.vsync), 0);
    check({tag, "_b_von"}, int'(if_b.video_on), 0);
    check({tag, "_b_fs"}, int'(if_b.frame_start), 0);
    check({tag, "_c_x"}, int'(if_c.X_pix), 0);
    check({tag, "_c_y"}, int'(if_c.Y_pix), 0);
    check({tag, "_c_hs"}, int'(if_c.hsync), 1);
    check({tag, "_d_hs"}, int'(if_d.hsync), 1);
    check({tag, "_d_von"}, int'(if_d.video_on), 0);
  endtask

  initial begin
    //           n    x   y  hs vs von fs fc hsb   (dut_a, plus dut_b hsync)
    vecs[0]  = '{0,   0,  0, 1, 1, 0, 1, 0, 0};
    vecs[1]  = '{1,   1,  0, 1, 1, 1, 0, 0, 0};
    vecs[2]  = '{8,   8,  0, 1, 1, 1, 0, 0, 0};
    vecs[3]  = '{9,   9,  0, 1, 1, 0, 0, 0, 0};
    vecs[4]  = '{10,  10, 0, 1, 1, 0, 0, 0, 1};
    vecs[5]  = '{11,  11, 0, 0, 1, 0, 0, 0, 1};
    vecs[6]  = '{12,  12, 0, 0, 1, 0, 0, 0, 1};
    vecs[7]  = '{13,  13, 0, 0, 1, 0, 0, 0, 0};
    vecs[8]  = '{14,  14, 0, 1, 1, 0, 0, 0, 0};
    vecs[9]  = '{16,  0,  1, 1, 1, 0, 0, 0, 0};
    vecs[10] = '{17,  1,  1, 1, 1, 1, 0, 0, 0};
    vecs[11] = '{112, 0,  7, 1, 1, 0, 0, 0, 0};
    vecs[12] = '{113, 1,  7, 1, 0, 0, 0, 0, 0};
    vecs[13] = '{144, 0,  9, 1, 0, 0, 0, 0, 0};
    vecs[14] = '{145, 1,  9, 1, 1, 0, 0, 0, 0};
    vecs[15] = '{175, 15, 10, 1, 1, 0, 0, 0, 0};
    vecs[16] = '{176, 0,  0, 1, 1, 0, 1, 1, 0};
    vecs[17] = '{177, 1,  0, 1, 1, 1, 0, 1, 0};

    // Held in reset for a few clocks.
    rst = 1'b1;
    repeat (3) @(negedge pixel_clk);
    #1;
    check_reset("rst");

    // Release between edges: origin visible, frame_start already high.
    @(negedge pixel_clk);
    rst = 1'b0;
    #1;
    n = 0;
    check_all();
    $display("release: X=%0d Y=%0d frame_start=%0d", if_a.X_pix, if_a.Y_pix, if_a.frame_start);

    // Hand-computed vectors over the first small frame.
    for (int i = 0; i < 18; i++) begin
      while (n < vecs[i].n) step();
      check("v_x", int'(if_a.X_pix), vecs[i].x);
      check("v_y", int'(if_a.Y_pix), vecs[i].y);
      check("v_hs", int'(if_a.hsync), int'(vecs[i].hs));
      check("v_vs", int'(if_a.vsync), int'(vecs[i].vs));
      check("v_von", int'(if_a.video_on), int'(vecs[i].von));
      check("v_fs", int'(if_a.frame_start), int'(vecs[i].fs));
      check("v_fc", int'(if_a.frame_count), vecs[i].fc);
      check("v_b_hs", int'(if_b.hsync), int'(vecs[i].hsb));
      $display("vec n=%0d X=%0d Y=%0d hs=%0d vs=%0d von=%0d fs=%0d fc=%0d b_hs=%0d",
               n, if_a.X_pix, if_a.Y_pix, if_a.hsync, if_a.vsync, if_a.video_on,
               if_a.frame_start, if_a.frame_count, if_b.hsync);
    end

    // 257 small frames: frame_count wraps through 255 -> 0 -> 1.
    while (n < SF * 257) step();
    check("a_fc_257", int'(if_a.frame_count), 1);
    check("a_fs_pulses", fs_a_cnt, 257);
    check("a_von_per_frame", von_a_cnt, 48);
    check("a_vsync_low_clks", vs_a_low, 2 * SH);
    check("c_hsync_low_clks", hs_c_low, 96);
    $display("frames: fc=%0d fs_pulses=%0d von=%0d vs_low=%0d c_hs_low=%0d",
             if_a.frame_count, fs_a_cnt, von_a_cnt, vs_a_low, hs_c_low);

    // Mid-frame reset asserted between edges takes effect at once.
    while ((n % SF) != 5 * SH + 6) step();
    #2;
    rst = 1'b1;
    #1;
    check_reset("async");
    $display("async rst: X=%0d Y=%0d c_X=%0d", if_a.X_pix, if_a.Y_pix, if_c.X_pix);
    @(negedge pixel_clk);
    rst = 1'b0;
    #1;
    n = 0;
    check_all();
    repeat (20) step();
    $display("resume: X=%0d Y=%0d", if_a.X_pix, if_a.Y_pix);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
